eth_cfg_regs: RTL and testbench

//  AXI4-Lite responder (slave) register bank through which a host configures and monitors
//  the 10G Ethernet path: enable, MAC addresses, frame sizes, status and frame counters.

---
 rtl/eth_cfg_regs.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_eth_cfg_regs.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_cfg_regs.sv
// eth_cfg_regs: AXI4-Lite responder register bank for the 10G Ethernet path.
// Holds enable/speed-up control, local and remote MAC addresses and frame sizes, and
// exposes link status, saturating frame counters and a version word to the host.
//
// Ports:
//   s_axi_aclk, s_axi_aresetn  clock and synchronous active-low reset
//   s_axi_aw*/w*/b*            write address / data / response channels
//   s_axi_ar*/r*               read address / data channels
//   eth_rst_done, eth_init_done  status inputs, already in the s_axi_aclk domain
//   tx_frame_pulse, rx_frame_pulse  one-cycle pulse per frame sent / received
//   eth_en, sim_speedup_control   control outputs
//   local_addr, remote_addr       48-bit MAC addresses
//   tx_size, rx_size              16-bit frame payload sizes in bytes
//
// Register map (byte offset): 0x00 CTRL, 0x04 STATUS (RO), 0x08/0x0C LADDR lo/hi,
// 0x10/0x14 RADDR lo/hi, 0x18 SIZE, 0x1C FRAME_CNT (any write clears), 0x20 SCRATCH,
// 0x24 VERSION (RO). Anything else is unmapped and answers SLVERR.
module eth_cfg_regs #(
   parameter int unsigned S_AXI_ADDR_WIDTH = 11,
   parameter int unsigned S_AXI_DATA_WIDTH = 32,
   parameter logic [47:0] LOCAL_ADDR_DEF   = 48'h000A35000001,
   parameter logic [47:0] REMOTE_ADDR_DEF  = 48'hFFFFFFFFFFFF,
   parameter logic [15:0] SIZE_DEF         = 16'd1024,
   parameter logic [31:0] VERSION          = 32'h0001_0000
) (
   input  logic                          s_axi_aclk,
   input  logic                          s_axi_aresetn,
   input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                          s_axi_awvalid,
   output logic                          s_axi_awready,
   input  logic [S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                          s_axi_wvalid,
   output logic                          s_axi_wready,
   output logic [1:0]                    s_axi_bresp,
   output logic                          s_axi_bvalid,
   input  logic                          s_axi_bready,
   input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                          s_axi_arvalid,
   output logic                          s_axi_arready,
   output logic [S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]                    s_axi_rresp,
   output logic                          s_axi_rvalid,
   input  logic                          s_axi_rready,
   input  logic                          eth_rst_done,
   input  logic                          eth_init_done,
   input  logic                          tx_frame_pulse,
   input  logic                          rx_frame_pulse,
   output logic                          eth_en,
   output logic                          sim_speedup_control,
   output logic [47:0]                   local_addr,
   output logic [47:0]                   remote_addr,
   output logic [15:0]                   tx_size,
   output logic [15:0]                   rx_size
);

   localparam int unsigned AW = S_AXI_ADDR_WIDTH;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;

   localparam logic [3:0] RegCtrl     = 4'd0;
   localparam logic [3:0] RegStatus   = 4'd1;
   localparam logic [3:0] RegLaddrLo  = 4'd2;
   localparam logic [3:0] RegLaddrHi  = 4'd3;
   localparam logic [3:0] RegRaddrLo  = 4'd4;
   localparam logic [3:0] RegRaddrHi  = 4'd5;
   localparam logic [3:0] RegSize     = 4'd6;
   localparam logic [3:0] RegFrameCnt = 4'd7;
   localparam logic [3:0] RegScratch  = 4'd8;
   localparam logic [3:0] RegVersion  = 4'd9;

   typedef enum logic [1:0] {WIdle, WHaveA, WHaveD, WResp} wstate_e;
   typedef enum logic {RIdle, RResp} rstate_e;

   // Register state
   logic [1:0]  ctrl_q;
   logic [47:0] laddr_q;
   logic [47:0] raddr_q;
   logic [15:0] tx_size_q;
   logic [15:0] rx_size_q;
   logic [31:0] scratch_q;
   logic [15:0] tx_cnt_q;
   logic [15:0] rx_cnt_q;

   // Handshake gating: readies stay low for one cycle after reset is released
   logic rst_rel_q;
   logic ready_en_q;

   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         rst_rel_q  <= 1'b0;
         ready_en_q <= 1'b0;
      end else begin
         rst_rel_q  <= 1'b1;
         ready_en_q <= rst_rel_q;
      end
   end

   // ---------------------------------------------------------------- write path
   wstate_e     wstate_q;
   logic [AW-1:0] awaddr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        bvalid_q;
   logic [1:0]  bresp_q;

   logic          aw_hs, w_hs, wr_commit, wr_mapped, reg_we, cnt_clr;
   logic [AW-1:0] wr_addr;
   logic [3:0]    wr_idx;
   logic [31:0]   wr_data, wr_cur, wr_merged;
   logic [3:0]    wr_strb;

   assign s_axi_awready = ready_en_q && (wstate_q == WIdle || wstate_q == WHaveD);
   assign s_axi_wready  = ready_en_q && (wstate_q == WIdle || wstate_q == WHaveA);
   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid && s_axi_wready;

   // Whichever half arrived earlier comes from the holding register, the other is live.
   assign wr_addr = (wstate_q == WHaveA) ? awaddr_q : s_axi_awaddr;
   assign wr_data = (wstate_q == WHaveD) ? wdata_q : s_axi_wdata;
   assign wr_strb = (wstate_q == WHaveD) ? wstrb_q : s_axi_wstrb;
   assign wr_idx  = wr_addr[5:2];
   assign wr_mapped = (wr_addr[AW-1:6] == '0) && (wr_idx <= RegVersion);

   always_comb begin
      wr_commit = 1'b0;
      case (wstate_q)
         WIdle:   wr_commit = aw_hs && w_hs;
         WHaveA:  wr_commit = w_hs;
         WHaveD:  wr_commit = aw_hs;
         default: wr_commit = 1'b0;
      endcase
   end

   assign reg_we  = wr_commit && wr_mapped;
   assign cnt_clr = reg_we && (wr_idx == RegFrameCnt);

   // Current value of the target register, merged byte-wise with the write data.
   always_comb begin
      wr_cur = '0;
      case (wr_idx)
         RegCtrl:    wr_cur = {30'd0, ctrl_q};
         RegLaddrLo: wr_cur = laddr_q[31:0];
         RegLaddrHi: wr_cur = {16'd0, laddr_q[47:32]};
         RegRaddrLo: wr_cur = raddr_q[31:0];
         RegRaddrHi: wr_cur = {16'd0, raddr_q[47:32]};
         RegSize:    wr_cur = {rx_size_q, tx_size_q};
         RegScratch: wr_cur = scratch_q;
         default:    wr_cur = '0;
      endcase
      wr_merged = wr_cur;
      for (int b = 0; b < 4; b++) begin
         if (wr_strb[b]) wr_merged[8*b +: 8] = wr_data[8*b +: 8];
      end
   end

   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         wstate_q <= WIdle;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bvalid_q <= 1'b0;
         bresp_q  <= RespOkay;
      end else begin
         unique case (wstate_q)
            WIdle: begin
               if (aw_hs && w_hs) begin
                  wstate_q <= WResp;
               end else if (aw_hs) begin
                  awaddr_q <= s_axi_awaddr;
                  wstate_q <= WHaveA;
               end else if (w_hs) begin
                  wdata_q  <= s_axi_wdata;
                  wstrb_q  <= s_axi_wstrb;
                  wstate_q <= WHaveD;
               end
            end
            WHaveA: if (w_hs) wstate_q <= WResp;
            WHaveD: if (aw_hs) wstate_q <= WResp;
            WResp: begin
               if (s_axi_bready) begin
                  bvalid_q <= 1'b0;
                  wstate_q <= WIdle;
               end
            end
            default: wstate_q <= WIdle;
         endcase
         if (wr_commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_mapped ? RespOkay : RespSlvErr;
         end
      end
   end

   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         ctrl_q    <= 2'b00;
         laddr_q   <= LOCAL_ADDR_DEF;
         raddr_q   <= REMOTE_ADDR_DEF;
         tx_size_q <= SIZE_DEF;
         rx_size_q <= SIZE_DEF;
         scratch_q <= '0;
      end else if (reg_we) begin
         case (wr_idx)
            RegCtrl:    ctrl_q          <= wr_merged[1:0];
            RegLaddrLo: laddr_q[31:0]   <= wr_merged;
            RegLaddrHi: laddr_q[47:32]  <= wr_merged[15:0];
            RegRaddrLo: raddr_q[31:0]   <= wr_merged;
            RegRaddrHi: raddr_q[47:32]  <= wr_merged[15:0];
            RegSize: begin
               tx_size_q <= wr_merged[15:0];
               rx_size_q <= wr_merged[31:16];
            end
            RegScratch: scratch_q       <= wr_merged;
            default: ;
         endcase
      end
   end

   // Saturating frame counters; a clear coinciding with a pulse leaves a count of one.
   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (cnt_clr) begin
            tx_cnt_q <= {15'd0, tx_frame_pulse};
            rx_cnt_q <= {15'd0, rx_frame_pulse};
         end else begin
            if (tx_frame_pulse && tx_cnt_q != 16'hFFFF) tx_cnt_q <= tx_cnt_q + 16'd1;
            if (rx_frame_pulse && rx_cnt_q != 16'hFFFF) rx_cnt_q <= rx_cnt_q + 16'd1;
         end
      end
   end

   // ----------------------------------------------------------------- read path
   rstate_e     rstate_q;
   logic [31:0] rdata_q;
   logic [1:0]  rresp_q;
   logic        rvalid_q;
   logic        ar_hs, rd_err;
   logic [31:0] rd_word;

   assign s_axi_arready = ready_en_q && (rstate_q == RIdle);
   assign ar_hs = s_axi_arvalid && s_axi_arready;

   always_comb begin
      rd_word = '0;
      rd_err  = 1'b0;
      if (s_axi_araddr[AW-1:6] != '0) begin
         rd_err = 1'b1;
      end else begin
         case (s_axi_araddr[5:2])
            RegCtrl:     rd_word = {30'd0, ctrl_q};
            RegStatus:   rd_word = {30'd0, eth_init_done, eth_rst_done};
            RegLaddrLo:  rd_word = laddr_q[31:0];
            RegLaddrHi:  rd_word = {16'd0, laddr_q[47:32]};
            RegRaddrLo:  rd_word = raddr_q[31:0];
            RegRaddrHi:  rd_word = {16'd0, raddr_q[47:32]};
            RegSize:     rd_word = {rx_size_q, tx_size_q};
            RegFrameCnt: rd_word = {rx_cnt_q, tx_cnt_q};
            RegScratch:  rd_word = scratch_q;
            RegVersion:  rd_word = VERSION;
            default:     rd_err  = 1'b1;
         endcase
      end
   end

   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         rstate_q <= RIdle;
         rdata_q  <= '0;
         rresp_q  <= RespOkay;
         rvalid_q <= 1'b0;
      end else begin
         unique case (rstate_q)
            RIdle: begin
               if (ar_hs) begin
                  rdata_q  <= rd_word;
                  rresp_q  <= rd_err ? RespSlvErr : RespOkay;
                  rvalid_q <= 1'b1;
                  rstate_q <= RResp;
               end
            end
            RResp: begin
               if (s_axi_rready) begin
                  rvalid_q <= 1'b0;
                  rstate_q <= RIdle;
               end
            end
            default: rstate_q <= RIdle;
         endcase
      end
   end

   // Byte-offset bits within a word carry no meaning here.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{s_axi_araddr[1:0], wr_addr[1:0]};

   // ------------------------------------------------------------------- outputs
   assign s_axi_bvalid = bvalid_q;
   assign s_axi_bresp  = bresp_q;
   assign s_axi_rvalid = rvalid_q;
   assign s_axi_rresp  = rresp_q;
   assign s_axi_rdata  = rdata_q;

   assign eth_en              = ctrl_q[0];
   assign sim_speedup_control = ctrl_q[1];
   assign local_addr          = laddr_q;
   assign remote_addr         = raddr_q;
   assign tx_size             = tx_size_q;
   assign rx_size             = rx_size_q;

endmodule

// File: tb/tb_eth_cfg_regs.sv
// Testbench for eth_cfg_regs: directed steps plus randomized register traffic checked
// against a field-level model of the register map.
module tb_eth_cfg_regs;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic [10:0] awaddr, araddr;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        eth_rst_done, eth_init_done, tx_frame_pulse, rx_frame_pulse;
   logic        eth_en, sim_speedup_control;
   logic [47:0] local_addr, remote_addr;
   logic [15:0] tx_size, rx_size;

   always #5 clk = ~clk;

   eth_cfg_regs dut (
      .s_axi_aclk          (clk),
      .s_axi_aresetn       (aresetn),
      .s_axi_awaddr        (awaddr),
      .s_axi_awvalid       (awvalid),
      .s_axi_awready       (awready),
      .s_axi_wdata         (wdata),
      .s_axi_wstrb         (wstrb),
      .s_axi_wvalid        (wvalid),
      .s_axi_wready        (wready),
      .s_axi_bresp         (bresp),
      .s_axi_bvalid        (bvalid),
      .s_axi_bready        (bready),
      .s_axi_araddr        (araddr),
      .s_axi_arvalid       (arvalid),
      .s_axi_arready       (arready),
      .s_axi_rdata         (rdata),
      .s_axi_rresp         (rresp),
      .s_axi_rvalid        (rvalid),
      .s_axi_rready        (rready),
      .eth_rst_done        (eth_rst_done),
      .eth_init_done       (eth_init_done),
      .tx_frame_pulse      (tx_frame_pulse),
      .rx_frame_pulse      (rx_frame_pulse),
      .eth_en              (eth_en),
      .sim_speedup_control (sim_speedup_control),
      .local_addr          (local_addr),
      .remote_addr         (remote_addr),
      .tx_size             (tx_size),
      .rx_size             (rx_size)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: one variable per architectural field.
   logic        m_en, m_sim;
   logic [47:0] m_laddr, m_raddr;
   logic [15:0] m_tx_size, m_rx_size;
   logic [31:0] m_scratch;
   int          m_txc, m_rxc;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void mdl_reset();
      m_en = 1'b0; m_sim = 1'b0;
      m_laddr = 48'h000A35000001; m_raddr = 48'hFFFFFFFFFFFF;
      m_tx_size = 16'd1024; m_rx_size = 16'd1024;
      m_scratch = 32'd0; m_txc = 0; m_rxc = 0;
   endfunction

   function automatic void mdl_pulse(input logic tx, input logic rx);
      if (tx && m_txc < 65535) m_txc++;
      if (rx && m_rxc < 65535) m_rxc++;
   endfunction

   function automatic void mdl_read(input logic [10:0] a, output logic [31:0] d,
                                    output logic [1:0] r);
      logic [15:0] tc, rc;
      tc = 16'(m_txc);
      rc = 16'(m_rxc);
      d = 32'd0;
      r = 2'b00;
      if (a[10:6] != 5'd0) begin
         r = 2'b10;
      end else begin
         case (a[5:2])
            4'd0: d = {30'd0, m_sim, m_en};
            4'd1: d = {30'd0, eth_init_done, eth_rst_done};
            4'd2: d = m_laddr[31:0];
            4'd3: d = {16'd0, m_laddr[47:32]};
            4'd4: d = m_raddr[31:0];
            4'd5: d = {16'd0, m_raddr[47:32]};
            4'd6: d = {m_rx_size, m_tx_size};
            4'd7: d = {rc, tc};
            4'd8: d = m_scratch;
            4'd9: d = 32'h0001_0000;
            default: r = 2'b10;
         endcase
      end
   endfunction

   function automatic void mdl_write(input logic [10:0] a, input logic [31:0] d,
                                     input logic [3:0] s, output logic [1:0] resp);
      logic [31:0] cur, nw;
      mdl_read(a, cur, resp);
      if (resp != 2'b00) return;
      nw = cur;
      for (int b = 0; b < 4; b++) if (s[b]) nw[8*b +: 8] = d[8*b +: 8];
      case (a[5:2])
         4'd0: begin m_en = nw[0]; m_sim = nw[1]; end
         4'd2: m_laddr[31:0] = nw;
         4'd3: m_laddr[47:32] = nw[15:0];
         4'd4: m_raddr[31:0] = nw;
         4'd5: m_raddr[47:32] = nw[15:0];
         4'd6: begin m_tx_size = nw[15:0]; m_rx_size = nw[31:16]; end
         4'd7: begin m_txc = 0; m_rxc = 0; end
         4'd8: m_scratch = nw;
         default: ;
      endcase
   endfunction

   task automatic check_outputs(input string tag);
      chk(tag, {eth_en, sim_speedup_control, local_addr, remote_addr, tx_size, rx_size},
          {m_en, m_sim, m_laddr, m_raddr, m_tx_size, m_rx_size});
   endtask

   // pulse is driven only on the cycle whose closing edge performs the commit.
   task automatic axi_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input logic pulse,
                            output logic [1:0] resp, output int bcyc);
      bit aw_done = 0;
      bit w_done = 0;
      bit aw_hs, w_hs;
      int t = 0;
      awaddr = a; wdata = d; wstrb = s; bready = 1'b1;
      resp = 2'bxx; bcyc = -1;
      while (!(aw_done && w_done) && t < 40) begin
         awvalid = !aw_done && (t >= aw_dly);
         wvalid  = !w_done && (t >= w_dly);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tx_frame_pulse = pulse && (aw_hs || aw_done) && (w_hs || w_done);
         tick();
         t++;
         aw_done |= aw_hs;
         w_done  |= w_hs;
      end
      awvalid = 1'b0; wvalid = 1'b0; tx_frame_pulse = 1'b0;
      while (t < 60) begin
         if (bvalid) begin
            resp = bresp;
            bcyc = t;
            tick();
            break;
         end
         tick();
         t++;
      end
      bready = 1'b0;
      if (bcyc < 0) chk("write_timeout", 0, 1);
   endtask

   task automatic axi_read(input logic [10:0] a, input logic pulse,
                           output logic [31:0] d, output logic [1:0] r);
      bit done = 0;
      bit hs;
      int t = 0;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      while (!done && t < 40) begin
         hs = arready;
         tx_frame_pulse = pulse && hs;
         tick();
         t++;
         done = hs;
      end
      arvalid = 1'b0; tx_frame_pulse = 1'b0;
      d = 32'hx; r = 2'bxx;
      done = 0;
      while (!done && t < 60) begin
         if (rvalid) begin
            d = rdata; r = rresp; done = 1;
         end
         tick();
         t++;
      end
      rready = 1'b0;
      if (!done) chk("read_timeout", 0, 1);
   endtask

   task automatic pulse_burst(input int n);
      for (int i = 0; i < n; i++) begin
         tx_frame_pulse = 1'($urandom_range(0, 1));
         rx_frame_pulse = 1'($urandom_range(0, 1));
         mdl_pulse(tx_frame_pulse, rx_frame_pulse);
         tick();
      end
      tx_frame_pulse = 1'b0; rx_frame_pulse = 1'b0;
   endtask

   initial begin
      logic [31:0] d, ed;
      logic [1:0]  r, er;
      int          bc;

      awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
      araddr = '0; arvalid = 0; rready = 0;
      eth_rst_done = 0; eth_init_done = 0; tx_frame_pulse = 0; rx_frame_pulse = 0;
      mdl_reset();

      // Reset and release
      repeat (3) tick();
      chk("rst_ready", {awready, wready, arready}, 3'b000);
      chk("rst_valid", {bvalid, rvalid}, 2'b00);
      chk("rst_resp_data", {bresp, rresp, rdata}, 36'd0);
      aresetn = 1'b1;
      chk("rel0_ready", {awready, wready, arready}, 3'b000);
      tick();
      chk("rel1_ready", {awready, wready, arready}, 3'b000);
      tick();
      chk("rel2_ready", {awready, wready, arready}, 3'b111);
      check_outputs("reset_outputs");

      axi_read(11'h00C, 1'b0, d, r);
      chk("rd_laddr_hi", {r, d}, {2'b00, 32'h0000_000A});
      axi_read(11'h008, 1'b0, d, r);
      chk("rd_laddr_lo", {r, d}, {2'b00, 32'h3500_0001});
      axi_read(11'h018, 1'b0, d, r);
      chk("rd_size", {r, d}, {2'b00, 32'h0400_0400});

      // AW first, W three cycles later
      axi_write(11'h018, 32'h0200_0040, 4'hF, 0, 3, 1'b0, r, bc);
      mdl_write(11'h018, 32'h0200_0040, 4'hF, er);
      chk("lat_bcycle", bc, 4);
      chk("lat_bresp", r, 2'b00);
      chk("lat_sizes", {tx_size, rx_size}, {16'd64, 16'd512});

      // Byte strobes on CTRL
      axi_write(11'h000, 32'h1, 4'b0000, 0, 0, 1'b0, r, bc);
      chk("strb0_bresp", r, 2'b00);
      chk("strb0_en", eth_en, 1'b0);
      axi_write(11'h000, 32'h1, 4'b0001, 1, 0, 1'b0, r, bc);
      mdl_write(11'h000, 32'h1, 4'b0001, er);
      chk("strb1_en", eth_en, 1'b1);

      // Unmapped offset
      axi_read(11'h030, 1'b0, d, r);
      chk("unmapped_read", {r, d}, {2'b10, 32'h0});
      axi_write(11'h030, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b0, r, bc);
      chk("unmapped_bresp", r, 2'b10);
      check_outputs("unmapped_outputs");

      // Randomized traffic
      for (int i = 0; i < 150; i++) begin
         logic [4:0]  hi;
         logic [3:0]  off;
         logic [1:0]  lo;
         logic [10:0] a;
         logic [31:0] wd;
         logic [3:0]  st;
         hi  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         off = 4'($urandom_range(0, 15));
         lo  = 2'($urandom_range(0, 3));
         a   = {hi, off, lo};
         wd  = $urandom;
         st  = 4'($urandom_range(0, 15));
         eth_rst_done  = 1'($urandom_range(0, 1));
         eth_init_done = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            axi_write(a, wd, st, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, r, bc);
            mdl_write(a, wd, st, er);
            chk("rnd_bresp", r, er);
            check_outputs("rnd_outputs");
         end else begin
            axi_read(a, 1'b0, d, r);
            mdl_read(a, ed, er);
            chk("rnd_read", {r, d}, {er, ed});
         end
         if ($urandom_range(0, 3) == 0) pulse_burst($urandom_range(1, 40));
      end

      // Read coinciding with a counter increment returns the old value
      pulse_burst(20);
      mdl_read(11'h01C, ed, er);
      axi_read(11'h01C, 1'b1, d, r);
      chk("rd_vs_pulse", {r, d}, {er, ed});
      mdl_pulse(1'b1, 1'b0);
      mdl_read(11'h01C, ed, er);
      axi_read(11'h01C, 1'b0, d, r);
      chk("rd_after_pulse", {r, d}, {er, ed});

      // Saturation
      tx_frame_pulse = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         mdl_pulse(1'b1, 1'b0);
         tick();
      end
      tx_frame_pulse = 1'b0;
      axi_read(11'h01C, 1'b0, d, r);
      chk("tx_cnt_sat", d[15:0], 16'hFFFF);
      mdl_read(11'h01C, ed, er);
      chk("frame_cnt_sat", {r, d}, {er, ed});

      // Clear with a coincident pulse
      axi_write(11'h01C, $urandom, 4'hF, 0, 0, 1'b1, r, bc);
      m_txc = 1; m_rxc = 0;
      axi_read(11'h01C, 1'b0, d, r);
      chk("clr_with_pulse", {r, d}, {2'b00, 32'h0000_0001});

      // Backpressure on B and R, then reset mid-response
      awaddr = 11'h020; wdata = 32'hA5A5_5A5A; wstrb = 4'hF; araddr = 11'h024;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      mdl_write(11'h020, 32'hA5A5_5A5A, 4'hF, er);
      for (int i = 0; i < 10; i++) begin
         chk("hold_valids", {bvalid, rvalid}, 2'b11);
         chk("hold_readies", {awready, wready, arready}, 3'b000);
         chk("hold_rdata", {rresp, rdata}, {2'b00, 32'h0001_0000});
         tick();
      end
      aresetn = 1'b0;
      tick();
      mdl_reset();
      chk("midrst_valids", {bvalid, rvalid}, 2'b00);
      chk("midrst_rdata", rdata, 32'h0);
      check_outputs("midrst_outputs");
      aresetn = 1'b1;
      tick();
      tick();
      axi_read(11'h020, 1'b0, d, r);
      chk("midrst_scratch", {r, d}, {2'b00, 32'h0});
      axi_read(11'h01C, 1'b0, d, r);
      chk("midrst_cnt", {r, d}, {2'b00, 32'h0});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
